// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the EX->MEM->WB datapath.
// Holds bus widths, mem_re size codes, exception bit indices and the packed
// views of the EX->MEM and MEM->WB bundles (fields listed MSB first).
package mem_stage_pkg;

    localparam int CSR_ZIP_W = 79;
    localparam int EXC_W     = 7;

    localparam int ES2MS_W   = 163;
    localparam int MS2WS_W   = 157;
    localparam int RF_ZIP_W  = 40;

    // mem_re doubles as the load size code
    localparam logic [3:0] BYTE = 4'h1;
    localparam logic [3:0] HALF = 4'h3;
    localparam logic [3:0] WORD = 4'hf;

    // Address-misaligned exception, raised in EX
    localparam int ALE = 6;

    typedef struct packed {
        logic [31:0]          pc;
        logic                 rf_we;
        logic [4:0]           rf_waddr;
        logic [31:0]          alu_result;
        logic                 res_from_mem;
        logic [3:0]           mem_re;
        logic                 mem_re_s;
        logic                 csr_re;
        logic [CSR_ZIP_W-1:0] csr_zip;
        logic [EXC_W-1:0]     except_zip;
    } es2ms_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic                 rf_we;
        logic [4:0]           rf_waddr;
        logic [31:0]          rf_wdata;
        logic                 csr_re;
        logic [CSR_ZIP_W-1:0] csr_zip;
        logic [EXC_W-1:0]     except_zip;
    } ms2ws_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the byte/half/word addressed by the low address bits and extends it.
// Latency: purely combinational.
// Backpressure: none, stateless.
// Ports: i_rdata (raw SRAM word), i_offset (addr[1:0]), i_mem_re (size code),
//        i_mem_re_s (sign-extend), o_result (aligned 32-bit value).
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [3:0]  i_mem_re,
    input  logic        i_mem_re_s,
    output logic [31:0] o_result
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    always_comb begin
        o_result = i_rdata;
        case (i_mem_re)
            WORD:    o_result = i_rdata;
            HALF:    o_result = {{16{i_mem_re_s & w_half[15]}}, w_half};
            BYTE:    o_result = {{24{i_mem_re_s & w_byte[7]}}, w_byte};
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EX bundle, aligns SRAM load data, merges exceptions, forwards to decode.
// Latency: one register stage from EX; outputs toward WB are combinational from that register.
// Backpressure: ms_allowin drops while holding a valid instruction WB will not take; first-cycle SRAM data is buffered meanwhile.
// Ports: clk/resetn (sync, active-low); es2ms_valid/es2ms_bus/ms_allowin from EX;
//        data_sram_rdata from SRAM; ms2ws_valid/ms2ws_bus/ws_allowin to WB;
//        ms_rf_zip forwarding to decode; ms_ex to EX; ws_ex flush from WB.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    output logic                ms_allowin,
    input  logic                es2ms_valid,
    input  logic [ES2MS_W-1:0]  es2ms_bus,
    input  logic [31:0]         data_sram_rdata,
    input  logic                ws_allowin,
    output logic                ms2ws_valid,
    output logic [MS2WS_W-1:0]  ms2ws_bus,
    output logic [RF_ZIP_W-1:0] ms_rf_zip,
    output logic                ms_ex,
    input  logic                ws_ex
);

    logic        r_valid;
    es2ms_t      r_bus;
    logic        r_first_cycle;
    logic [31:0] r_rdata_buf;
    logic        r_rdata_buf_valid;

    es2ms_t      w_in;
    ms2ws_t      w_out;
    logic        w_load;
    logic        w_has_exc;
    logic [31:0] w_rdata;
    logic [31:0] w_load_data;
    logic [31:0] w_rf_wdata;

    assign w_in       = es2ms_bus;
    assign ms_allowin = ~r_valid | ws_allowin;
    assign w_load     = es2ms_valid & ms_allowin & ~ws_ex;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid           <= 1'b0;
            r_bus             <= '0;
            r_first_cycle     <= 1'b0;
            r_rdata_buf       <= '0;
            r_rdata_buf_valid <= 1'b0;
        end else begin
            if (ws_ex) begin
                r_valid <= 1'b0;
            end else if (ms_allowin) begin
                r_valid <= es2ms_valid;
            end

            if (w_load) begin
                r_bus <= w_in;
            end

            r_first_cycle <= w_load;

            // SRAM data is only valid in the first MEM cycle; keep it if WB stalls us there
            if (w_load || ws_ex) begin
                r_rdata_buf_valid <= 1'b0;
            end else if (r_valid && r_first_cycle && !ws_allowin) begin
                r_rdata_buf       <= data_sram_rdata;
                r_rdata_buf_valid <= 1'b1;
            end
        end
    end

    assign w_rdata = r_rdata_buf_valid ? r_rdata_buf : data_sram_rdata;

    load_align u_load_align (
        .i_rdata    (w_rdata),
        .i_offset   (r_bus.alu_result[1:0]),
        .i_mem_re   (r_bus.mem_re),
        .i_mem_re_s (r_bus.mem_re_s),
        .o_result   (w_load_data)
    );

    assign w_rf_wdata = r_bus.res_from_mem ? w_load_data : r_bus.alu_result;
    assign w_has_exc  = |r_bus.except_zip;

    // A faulting instruction still reaches WB to raise the trap, but must not write the RF
    assign w_out.pc         = r_bus.pc;
    assign w_out.rf_we      = r_bus.rf_we & ~w_has_exc;
    assign w_out.rf_waddr   = r_bus.rf_waddr;
    assign w_out.rf_wdata   = w_rf_wdata;
    assign w_out.csr_re     = r_bus.csr_re;
    assign w_out.csr_zip    = r_bus.csr_zip;
    assign w_out.except_zip = r_bus.except_zip;

    assign ms2ws_valid = r_valid;
    assign ms2ws_bus   = w_out;
    assign ms_ex       = r_valid & w_has_exc;
    assign ms_rf_zip   = {r_bus.csr_re & r_valid, 1'b0,
                          r_bus.rf_we & r_valid & ~w_has_exc,
                          r_bus.rf_waddr, w_rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load alignment, WB stall buffering, flush, exception masking, streaming.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         ms_allowin;
    logic         es2ms_valid;
    logic [162:0] es2ms_bus;
    logic [31:0]  data_sram_rdata;
    logic         ws_allowin;
    logic         ms2ws_valid;
    logic [156:0] ms2ws_bus;
    logic [39:0]  ms_rf_zip;
    logic         ms_ex;
    logic         ws_ex;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ms_allowin      (ms_allowin),
        .es2ms_valid     (es2ms_valid),
        .es2ms_bus       (es2ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ws_allowin      (ws_allowin),
        .ms2ws_valid     (ms2ws_valid),
        .ms2ws_bus       (ms2ws_bus),
        .ms_rf_zip       (ms_rf_zip),
        .ms_ex           (ms_ex),
        .ws_ex           (ws_ex)
    );

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // EX bundle, MSB first: pc, rf_we, rf_waddr, alu_result, res_from_mem, mem_re, mem_re_s, csr_re, csr_zip, except_zip
    function automatic logic [162:0] mk(input logic [31:0] pc, input logic rf_we, input logic [4:0] waddr,
                                        input logic [31:0] alu, input logic rfm, input logic [3:0] mem_re,
                                        input logic s, input logic csr_re, input logic [78:0] csr,
                                        input logic [6:0] exc);
        mk = {pc, rf_we, waddr, alu, rfm, mem_re, s, csr_re, csr, exc};
    endfunction

    // EX offers b for one cycle; returns #1 into its first MEM cycle with the SRAM data applied
    task automatic send(input logic [162:0] b, input logic [31:0] rd);
        @(negedge clk);
        es2ms_valid = 1'b1;
        es2ms_bus   = b;
        @(negedge clk);
        es2ms_valid     = 1'b0;
        data_sram_rdata = rd;
        #1;
    endtask

    logic [78:0] csr_pat;

    initial begin
        csr_pat         = 79'h4A_5A5A_1234_5678_9ABC;
        resetn          = 1'b0;
        es2ms_valid     = 1'b0;
        es2ms_bus       = '0;
        data_sram_rdata = '0;
        ws_allowin      = 1'b1;
        ws_ex           = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ms2ws_valid", ms2ws_valid, 0);
        chk("rst_ms_ex", ms_ex, 0);
        chk("rst_rf_zip", ms_rf_zip, 0);
        chk("rst_allowin", ms_allowin, 1);
        chk("rst_bus", ms2ws_bus, 0);
        resetn = 1'b1;

        // ld.b signed, offset 3 -> byte 0x80
        send(mk(32'h1c00_0000, 1'b1, 5'd5, 32'h0000_1003, 1'b1, 4'h1, 1'b1, 1'b0, csr_pat, 7'h0), 32'h80FF_1234);
        chk("ldb_s_wdata", ms2ws_bus[118:87], 32'hFFFF_FF80);
        chk("ldb_s_valid", ms2ws_valid, 1);
        chk("ldb_s_rfzip", ms_rf_zip, {1'b0, 1'b0, 1'b1, 5'd5, 32'hFFFF_FF80});
        chk("ldb_s_csrzip", ms2ws_bus[85:7], csr_pat);
        chk("ldb_s_pc", ms2ws_bus[156:125], 32'h1c00_0000);

        // ld.bu
        send(mk(32'h1c00_0004, 1'b1, 5'd6, 32'h0000_1003, 1'b1, 4'h1, 1'b0, 1'b0, csr_pat, 7'h0), 32'h80FF_1234);
        chk("ldb_u_wdata", ms2ws_bus[118:87], 32'h0000_0080);

        // ld.h signed, offset 2
        send(mk(32'h1c00_0008, 1'b1, 5'd7, 32'h0000_2002, 1'b1, 4'h3, 1'b1, 1'b0, csr_pat, 7'h0), 32'h8001_7FFF);
        chk("ldh_s_wdata", ms2ws_bus[118:87], 32'hFFFF_8001);

        // ld.hu, offset 0
        send(mk(32'h1c00_000c, 1'b1, 5'd8, 32'h0000_2000, 1'b1, 4'h3, 1'b0, 1'b1, csr_pat, 7'h0), 32'h8001_7FFF);
        chk("ldh_u_wdata", ms2ws_bus[118:87], 32'h0000_7FFF);
        chk("ldh_u_csr_fwd", ms_rf_zip[39], 1);

        // ld.w with WB stalled for 3 cycles while SRAM data changes and EX keeps offering
        send(mk(32'h1c00_0010, 1'b1, 5'd9, 32'h0000_3000, 1'b1, 4'hf, 1'b0, 1'b0, csr_pat, 7'h0), 32'h1234_5678);
        ws_allowin  = 1'b0;
        es2ms_valid = 1'b1;
        es2ms_bus   = mk(32'h1c00_0BAD, 1'b1, 5'd10, 32'h0000_BAD0, 1'b0, 4'h0, 1'b0, 1'b0, csr_pat, 7'h0);
        #1;
        chk("stall_c1_wdata", ms2ws_bus[118:87], 32'h1234_5678);
        chk("stall_c1_allowin", ms_allowin, 0);
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            data_sram_rdata = 32'hDEAD_BEEF;
            #1;
            chk($sformatf("stall_c%0d_wdata", c), ms2ws_bus[118:87], 32'h1234_5678);
            chk($sformatf("stall_c%0d_pc", c), ms2ws_bus[156:125], 32'h1c00_0010);
            chk($sformatf("stall_c%0d_valid", c), ms2ws_valid, 1);
        end
        @(negedge clk);
        ws_allowin = 1'b1;
        #1;
        chk("stall_rel_wdata", ms2ws_bus[118:87], 32'h1234_5678);
        chk("stall_rel_allowin", ms_allowin, 1);
        @(negedge clk);
        es2ms_valid = 1'b0;
        #1;
        chk("stall_next_pc", ms2ws_bus[156:125], 32'h1c00_0BAD);
        chk("stall_next_wdata", ms2ws_bus[118:87], 32'h0000_BAD0);

        // WB flush while EX offers a new (faulting) instruction
        send(mk(32'h1c00_0020, 1'b1, 5'd11, 32'h0000_0055, 1'b0, 4'h0, 1'b0, 1'b0, csr_pat, 7'h0), 32'h0);
        es2ms_valid = 1'b1;
        es2ms_bus   = mk(32'h1c00_0024, 1'b1, 5'd12, 32'h0000_0066, 1'b0, 4'h0, 1'b0, 1'b0, csr_pat, 7'h01);
        ws_ex       = 1'b1;
        @(negedge clk);
        ws_ex       = 1'b0;
        es2ms_valid = 1'b0;
        #1;
        chk("flush_valid", ms2ws_valid, 0);
        chk("flush_ms_ex", ms_ex, 0);
        chk("flush_rfzip_we", ms_rf_zip[37], 0);
        chk("flush_pc_not_loaded", ms2ws_bus[156:125], 32'h1c00_0020);

        // ALE exception: flows to WB with rf_we masked
        send(mk(32'h1c00_0030, 1'b1, 5'd13, 32'h0000_0077, 1'b0, 4'h0, 1'b0, 1'b0, csr_pat, 7'h40), 32'h0);
        chk("ale_ms_ex", ms_ex, 1);
        chk("ale_valid", ms2ws_valid, 1);
        chk("ale_bus_we", ms2ws_bus[124], 0);
        chk("ale_rfzip_we", ms_rf_zip[37], 0);
        chk("ale_exc", ms2ws_bus[6:0], 7'h40);

        // Back-to-back ALU ops, one retire per cycle
        @(negedge clk);
        es2ms_valid = 1'b1;
        es2ms_bus   = mk(32'h1c00_0100, 1'b1, 5'd1, 32'h0000_0100, 1'b0, 4'h0, 1'b0, 1'b0, csr_pat, 7'h0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("b2b%0d_wdata", i - 1), ms2ws_bus[118:87], 32'h100 + 32'(i - 1) * 32'h11);
            chk($sformatf("b2b%0d_valid", i - 1), ms2ws_valid, 1);
            chk($sformatf("b2b%0d_allowin", i - 1), ms_allowin, 1);
            if (i < 4) begin
                es2ms_bus = mk(32'h1c00_0100 + 32'(i) * 4, 1'b1, 5'(i + 1), 32'h100 + 32'(i) * 32'h11,
                               1'b0, 4'h0, 1'b0, 1'b0, csr_pat, 7'h0);
            end else begin
                es2ms_valid = 1'b0;
            end
        end

        // Reset with a valid instruction in MEM
        resetn = 1'b0;
        @(negedge clk);
        #1;
        resetn = 1'b1;
        chk("midrst_valid", ms2ws_valid, 0);
        chk("midrst_bus", ms2ws_bus, 0);
        chk("midrst_allowin", ms_allowin, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
